aes_sbox_sched: RTL and testbench

- Time-multiplexes a small bank of LANES combinational AES S-box lookups between two requesters.
  - State path: SubBytes on a 128-bit state.
  - Key-expansion path: SubWord on a 32-bit word.
- S-box instances sit outside this block. It drives their inputs and samples their outputs in the same cycle.
- One job is in flight at a time. Both requesters use valid/ready request and response handshakes.

---
 rtl/aes_sbox_sched.sv | 127 ++++++++++++
 tb/tb_aes_sbox_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: shares LANES external S-box lookups between a SubBytes state path and a SubWord key path.
// Latency: response valid 16/LANES (state) or 4/LANES (key) cycles after accept; one job in flight.
// Backpressure: request ready only in IDLE; the result is held in HOLD until its rsp_ready.
module aes_sbox_sched #(
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 st_req_valid,
   output logic                 st_req_ready,
   input  logic [127:0]         st_req_data,
   output logic                 st_rsp_valid,
   input  logic                 st_rsp_ready,
   output logic [127:0]         st_rsp_data,
   input  logic                 kw_req_valid,
   output logic                 kw_req_ready,
   input  logic [31:0]          kw_req_data,
   output logic                 kw_rsp_valid,
   input  logic                 kw_rsp_ready,
   output logic [31:0]          kw_rsp_data,
   output logic [8*LANES-1:0]   sbox_in,
   input  logic [8*LANES-1:0]   sbox_out,
   output logic                 busy
);

   localparam int ST_BEATS = 16 / LANES;
   localparam int KW_BEATS = 4 / LANES;
   localparam int LW       = 8 * LANES;

   if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("aes_sbox_sched: LANES must be 1, 2 or 4");
   end

   typedef enum logic [2:0] {IDLE, RUN_ST, RUN_KW, HOLD_ST, HOLD_KW} state_t;
   typedef enum logic {GRANT_ST, GRANT_KW} grant_t;

   state_t        state, state_nxt;
   grant_t        last_grant;
   logic [3:0]    beat;
   logic [127:0]  work;       // bytes 0..15 of the job, byte 0 at the top
   logic [127:0]  st_res;
   logic [31:0]   kw_res;
   logic          last_beat;
   logic [6:0]    st_base;    // top bit of the current beat's slice in a 128-bit vector
   logic [4:0]    kw_base;    // same for the 32-bit key result

   // Round-robin arbitration; ready is also qualified by the requester's own
   // valid so that an idle block with no requests shows ready low.
   always_comb begin
      st_req_ready = (state == IDLE) && st_req_valid &&
                     (!kw_req_valid || last_grant == GRANT_KW);
      kw_req_ready = (state == IDLE) && kw_req_valid &&
                     (!st_req_valid || last_grant == GRANT_ST);
   end

   // Beat slice positions and end-of-job detection.
   always_comb begin
      st_base   = 7'(127 - LW * int'(beat));
      kw_base   = 5'(31 - LW * int'(beat));
      last_beat = (state == RUN_ST && beat == 4'(ST_BEATS - 1)) ||
                  (state == RUN_KW && beat == 4'(KW_BEATS - 1));
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (st_req_ready)      state_nxt = RUN_ST;
            else if (kw_req_ready) state_nxt = RUN_KW;
         end
         RUN_ST:  if (last_beat)    state_nxt = HOLD_ST;
         RUN_KW:  if (last_beat)    state_nxt = HOLD_KW;
         HOLD_ST: if (st_rsp_ready) state_nxt = IDLE;
         HOLD_KW: if (kw_rsp_ready) state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the state; S-box inputs are zero outside RUN states.
   always_comb begin
      st_rsp_valid = (state == HOLD_ST);
      kw_rsp_valid = (state == HOLD_KW);
      busy         = (state != IDLE);
      st_rsp_data  = st_res;
      kw_rsp_data  = kw_res;
      sbox_in      = '0;
      if (state == RUN_ST || state == RUN_KW) sbox_in = work[st_base -: LW];
   end

   // State register, job capture and per-beat result write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         beat       <= '0;
         last_grant <= GRANT_ST;
         work       <= '0;
         st_res     <= '0;
         kw_res     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (st_req_ready) begin
                  work       <= st_req_data;
                  last_grant <= GRANT_ST;
                  beat       <= '0;
               end else if (kw_req_ready) begin
                  work       <= {kw_req_data, 96'd0};
                  last_grant <= GRANT_KW;
                  beat       <= '0;
               end
            end
            RUN_ST: begin
               st_res[st_base -: LW] <= sbox_out;
               beat                  <= beat + 4'd1;
            end
            RUN_KW: begin
               kw_res[kw_base -: LW] <= sbox_out;
               beat                  <= beat + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// tb_aes_sbox_sched: randomized jobs against a job-level reference model, plus LANES=1 latency checks.
// Latency: model expects response BEATS cycles after accept.
// Backpressure: random and forced rsp_ready stalls exercise HOLD.
module tb_aes_sbox_sched;

   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [2047:0] t;
      logic [10:0]   idx;
      t   = SBOX_TAB;
      idx = 11'(2047 - 8 * int'(x));
      return t[idx -: 8];
   endfunction

   function automatic logic [127:0] sub128(input logic [127:0] d);
      logic [127:0] r, t;
      r = '0; t = d;
      for (int k = 0; k < 16; k++) begin
         r = {r[119:0], sb(t[127:120])};
         t = t << 8;
      end
      return r;
   endfunction

   function automatic logic [31:0] sub32(input logic [31:0] d);
      return {sb(d[31:24]), sb(d[23:16]), sb(d[15:8]), sb(d[7:0])};
   endfunction

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // LANES=4 instance
   logic         st_req_valid, st_req_ready, st_rsp_valid, st_rsp_ready;
   logic [127:0] st_req_data, st_rsp_data;
   logic         kw_req_valid, kw_req_ready, kw_rsp_valid, kw_rsp_ready;
   logic [31:0]  kw_req_data, kw_rsp_data;
   logic [31:0]  sbox_in, sbox_out;
   logic         busy;

   assign sbox_out = {sb(sbox_in[31:24]), sb(sbox_in[23:16]), sb(sbox_in[15:8]), sb(sbox_in[7:0])};

   aes_sbox_sched #(.LANES(4)) dut (
      .clk(clk), .rst(rst),
      .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_data(st_req_data),
      .st_rsp_valid(st_rsp_valid), .st_rsp_ready(st_rsp_ready), .st_rsp_data(st_rsp_data),
      .kw_req_valid(kw_req_valid), .kw_req_ready(kw_req_ready), .kw_req_data(kw_req_data),
      .kw_rsp_valid(kw_rsp_valid), .kw_rsp_ready(kw_rsp_ready), .kw_rsp_data(kw_rsp_data),
      .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy));

   // LANES=1 instance
   logic         n1_st_req_valid, n1_st_req_ready, n1_st_rsp_valid, n1_st_rsp_ready;
   logic [127:0] n1_st_req_data, n1_st_rsp_data;
   logic         n1_kw_req_valid, n1_kw_req_ready, n1_kw_rsp_valid, n1_kw_rsp_ready;
   logic [31:0]  n1_kw_req_data, n1_kw_rsp_data;
   logic [7:0]   n1_sbox_in, n1_sbox_out;
   logic         n1_busy;

   assign n1_sbox_out = sb(n1_sbox_in);

   aes_sbox_sched #(.LANES(1)) dut_n1 (
      .clk(clk), .rst(rst),
      .st_req_valid(n1_st_req_valid), .st_req_ready(n1_st_req_ready), .st_req_data(n1_st_req_data),
      .st_rsp_valid(n1_st_rsp_valid), .st_rsp_ready(n1_st_rsp_ready), .st_rsp_data(n1_st_rsp_data),
      .kw_req_valid(n1_kw_req_valid), .kw_req_ready(n1_kw_req_ready), .kw_req_data(n1_kw_req_data),
      .kw_rsp_valid(n1_kw_rsp_valid), .kw_rsp_ready(n1_kw_rsp_ready), .kw_rsp_data(n1_kw_rsp_data),
      .sbox_in(n1_sbox_in), .sbox_out(n1_sbox_out), .busy(n1_busy));

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Job-level reference model
   int           cyc = 0;
   bit           m_busy, m_kw, m_last_kw;
   logic [127:0] m_job;          // job bytes, byte 0 at the top
   int           m_acc, m_beats;
   logic [127:0] m_st_last;
   logic [31:0]  m_kw_last;

   logic [127:0] st_q[$];
   logic [31:0]  kw_q[$];
   logic [127:0] st_seen_q[$];
   logic [31:0]  kw_seen_q[$];
   bit           grants[$];      // 1 = key job granted
   bit           st_f, kw_f, st_rf, kw_rf;
   bit           rand_bp = 1'b0;
   int           st_hold_cnt = 0;

   task automatic drive_reqs();
      st_req_valid = (st_q.size() > 0);
      st_req_data  = (st_q.size() > 0) ? st_q[0] : '0;
      kw_req_valid = (kw_q.size() > 0);
      kw_req_data  = (kw_q.size() > 0) ? kw_q[0] : '0;
   endtask

   // One clock: check outputs at the falling edge, advance the model at the rising edge.
   task automatic tick();
      int           b;
      bit           run, hold, win_st, win_kw;
      logic [127:0] sh, exp_in;
      @(negedge clk);
      st_f = 0; kw_f = 0; st_rf = 0; kw_rf = 0;
      if (!rst) begin
         b      = cyc - m_acc;
         run    = m_busy && (b < m_beats);
         hold   = m_busy && (b >= m_beats);
         win_st = !m_busy && st_req_valid && (!kw_req_valid || m_last_kw);
         win_kw = !m_busy && kw_req_valid && (!st_req_valid || !m_last_kw);
         check("st_req_ready", st_req_ready, win_st);
         check("kw_req_ready", kw_req_ready, win_kw);
         check("busy", busy, m_busy);
         check("st_rsp_valid", st_rsp_valid, hold && !m_kw);
         check("kw_rsp_valid", kw_rsp_valid, hold && m_kw);
         sh     = m_job << (32 * b);
         exp_in = run ? {96'd0, sh[127:96]} : '0;
         check("sbox_in", sbox_in, exp_in);
         if (!(run && !m_kw))
            check("st_rsp_data", st_rsp_data, (hold && !m_kw) ? sub128(m_job) : m_st_last);
         if (!(run && m_kw))
            check("kw_rsp_data", kw_rsp_data, (hold && m_kw) ? sub32(m_job[127:96]) : m_kw_last);
         st_f  = st_req_valid & st_req_ready;
         kw_f  = kw_req_valid & kw_req_ready;
         st_rf = st_rsp_valid & st_rsp_ready;
         kw_rf = kw_rsp_valid & kw_rsp_ready;
         if (st_rf) st_seen_q.push_back(st_rsp_data);
         if (kw_rf) kw_seen_q.push_back(kw_rsp_data);
         if (st_rsp_valid && st_hold_cnt > 0) st_hold_cnt--;
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_busy = 0; m_last_kw = 0; m_st_last = '0; m_kw_last = '0;
      end else begin
         if (st_rf) begin m_st_last = sub128(m_job); m_busy = 0; end
         if (kw_rf) begin m_kw_last = sub32(m_job[127:96]); m_busy = 0; end
         if (st_f) begin
            m_busy = 1; m_kw = 0; m_job = st_req_data; m_acc = cyc; m_beats = 4;
            m_last_kw = 0; grants.push_back(1'b0);
         end else if (kw_f) begin
            m_busy = 1; m_kw = 1; m_job = {kw_req_data, 96'd0}; m_acc = cyc; m_beats = 1;
            m_last_kw = 1; grants.push_back(1'b1);
         end
      end
      #1;
      if (st_f) void'(st_q.pop_front());
      if (kw_f) void'(kw_q.pop_front());
      drive_reqs();
      st_rsp_ready = (st_hold_cnt > 0) ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
      kw_rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic run_until_idle(input int maxc);
      int n = 0;
      while ((st_q.size() > 0 || kw_q.size() > 0 || m_busy) && n < maxc) begin
         tick();
         n++;
      end
      check("drain_in_time", n < maxc, 1);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Single directed job on the LANES=1 instance; latency counted in edges after accept.
   task automatic n1_job(input bit is_kw, input logic [127:0] d, input logic [127:0] exp,
                         input int exp_lat, input string tag);
      int  t, lat;
      bit  rdy;
      @(posedge clk); #1;
      if (is_kw) begin n1_kw_req_valid = 1; n1_kw_req_data = d[31:0]; end
      else       begin n1_st_req_valid = 1; n1_st_req_data = d;       end
      #1;
      t = 0;
      rdy = is_kw ? n1_kw_req_ready : n1_st_req_ready;
      while (!rdy && t < 20) begin
         @(posedge clk); #1; t++;
         rdy = is_kw ? n1_kw_req_ready : n1_st_req_ready;
      end
      check({tag, "_accept"}, rdy, 1);
      @(posedge clk); #1;
      n1_kw_req_valid = 0; n1_st_req_valid = 0;
      lat = 0;
      while (!(is_kw ? n1_kw_rsp_valid : n1_st_rsp_valid) && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_data"}, is_kw ? {96'd0, n1_kw_rsp_data} : n1_st_rsp_data, exp);
      n1_kw_rsp_ready = 1; n1_st_rsp_ready = 1;
      @(posedge clk); #1;
      n1_kw_rsp_ready = 0; n1_st_rsp_ready = 0;
      check({tag, "_idle"}, n1_busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n;
      logic [5:0]  gpat;
      rst = 1'b1;
      st_rsp_ready = 0; kw_rsp_ready = 0;
      n1_st_req_valid = 0; n1_st_req_data = '0; n1_st_rsp_ready = 0;
      n1_kw_req_valid = 0; n1_kw_req_data = '0; n1_kw_rsp_ready = 0;
      drive_reqs();
      repeat (2) tick();
      rst = 1'b0;
      tick();                                   // reset state checked by the model

      // Each valid raised alone sees ready.
      st_req_valid = 1; #1;
      check("alone_st_ready", st_req_ready, 1);
      st_req_valid = 0; kw_req_valid = 1; #1;
      check("alone_kw_ready", kw_req_ready, 1);
      kw_req_valid = 0;

      // Continuous ties: KW first after reset, then alternation.
      grants.delete(); st_seen_q.delete(); kw_seen_q.delete();
      st_q.push_back(128'h193de3bea0f4e22b9ac68d2ae9f84808);
      st_q.push_back(rnd128()); st_q.push_back(rnd128());
      kw_q.push_back(32'hcf4f3c09);
      kw_q.push_back($urandom); kw_q.push_back($urandom);
      drive_reqs();
      run_until_idle(200);
      check("grant_count", grants.size(), 6);
      gpat = '0;
      foreach (grants[i]) if (i < 6) gpat = {gpat[4:0], grants[i]};
      check("grant_order", gpat, 6'b101010);
      check("kat_state", st_seen_q.size() > 0 ? st_seen_q[0] : '0,
            128'hd42711aee0bf98f1b8b45de51e415230);
      check("kat_key", kw_seen_q.size() > 0 ? kw_seen_q[0] : '0, 32'h8a84eb01);

      // Long stall in HOLD_ST with a key request waiting.
      st_hold_cnt = 10;
      st_q.push_back(rnd128());
      drive_reqs();
      tick(); tick();
      kw_q.push_back($urandom);
      drive_reqs();
      run_until_idle(100);
      check("hold_released", st_hold_cnt, 0);

      // Reset during beat 2 of a state job.
      st_q.push_back(rnd128());
      drive_reqs();
      n = 0;
      while (!(m_busy && cyc - m_acc == 2) && n < 20) begin tick(); n++; end
      check("reached_beat2", n < 20, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      st_seen_q.delete();
      st_q.push_back(128'h000102030405060708090a0b0c0d0e0f);
      drive_reqs();
      run_until_idle(100);
      check("kat_after_reset", st_seen_q.size() > 0 ? st_seen_q[0] : '0,
            128'h637c777bf26b6fc53001672bfed7ab76);

      // Random traffic with random response backpressure.
      rand_bp = 1'b1;
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(0, 3);
         if (n[0]) st_q.push_back(rnd128());
         if (n[1]) kw_q.push_back($urandom);
         drive_reqs();
         repeat ($urandom_range(0, 8)) tick();
      end
      run_until_idle(3000);
      rand_bp = 1'b0;
      st_rsp_ready = 0; kw_rsp_ready = 0;

      // LANES=1 latency and data.
      n1_job(1'b1, {96'd0, 32'hcf4f3c09}, {96'd0, 32'h8a84eb01}, 4, "n1_key");
      n1_job(1'b0, 128'h000102030405060708090a0b0c0d0e0f,
             128'h637c777bf26b6fc53001672bfed7ab76, 16, "n1_state");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
